pll_lock_sequencer: RTL and testbench



---
 rtl/pll_seq_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/pll_lock_sequencer.sv | 119 +++++++++++
 tb/tb_pll_lock_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : pll_seq_pkg
// Brief  : State encoding shared by the PLL lock sequencer and its users.
// Rev    : 1.0
// ============================================================================
package pll_seq_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_RST    = 3'd0,
      S_WAIT   = 3'd1,
      S_STABLE = 3'd2,
      S_RUN    = 3'd3,
      S_FAULT  = 3'd4,
      S_PDN    = 3'd5
   } state_e;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module : sync_2ff
// Brief  : Single-bit two-flop synchroniser with synchronous clear to 0.
// Rev    : 1.0
// ============================================================================
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module : pll_lock_sequencer
// Brief  : Power-up, reset pulse, lock timeout/retry and lock qualification
//          for one PLL; publishes READY and a sticky FAULT.
// Rev    : 1.0
// ============================================================================
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 65536,
   parameter int unsigned STABLE_CYCLES = 64,
   parameter int unsigned MAX_RETRIES   = 3,
   parameter int unsigned CNT_W         = 17
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               pwrdwn_req_i,
   input  logic               pll_locked_i,
   output logic               pll_rst_o,
   output logic               pll_pwrdwn_o,
   output logic               ready_o,
   output logic               fault_o,
   output logic [1:0]         retry_cnt_o,
   output logic [STATE_W-1:0] state_o
);

   localparam logic [CNT_W-1:0] c_rst_last  = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_to_last   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] c_stb_last  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
   localparam logic [1:0]       c_max_retry = (MAX_RETRIES > 3) ? 2'd3 : 2'(MAX_RETRIES);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       retry_q, retry_d;
   logic             fault_q, fault_d;
   logic             ready_q;
   logic             lk_s;

   sync_2ff u_lock_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (pll_locked_i),
      .q_o   (lk_s)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_RST;
         cnt_q   <= '0;
         retry_q <= '0;
         fault_q <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         fault_q <= fault_d;
         ready_q <= (state_d == S_RUN);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + c_cnt_one;
      retry_d = retry_q;
      fault_d = fault_q;
      if (pwrdwn_req_i) begin
         state_d = S_PDN;
      end else begin
         case (state_q)
            S_RST:    if (cnt_q == c_rst_last) state_d = S_WAIT;
            S_WAIT: begin
               if (lk_s) begin
                  state_d = S_STABLE;
               end else if (cnt_q == c_to_last) begin
                  // Increment only below the budget, so the count cannot wrap.
                  if (retry_q < c_max_retry) begin
                     retry_d = retry_q + 2'd1;
                     state_d = S_RST;
                  end else begin
                     fault_d = 1'b1;
                     state_d = S_FAULT;
                  end
               end
            end
            S_STABLE: begin
               if (!lk_s)                    state_d = S_WAIT;
               else if (cnt_q == c_stb_last) state_d = S_RUN;
            end
            S_RUN: begin
               if (!lk_s) begin
                  retry_d = '0;
                  state_d = S_RST;
               end
            end
            S_FAULT:  state_d = S_FAULT;
            S_PDN: begin
               retry_d = '0;
               fault_d = 1'b0;
               state_d = S_RST;
            end
            default:  state_d = S_RST;
         endcase
      end
      if (state_d != state_q) cnt_d = '0;
   end

   assign pll_rst_o    = (state_q != S_WAIT) && (state_q != S_STABLE) && (state_q != S_RUN);
   assign pll_pwrdwn_o = (state_q == S_PDN);
   assign ready_o      = ready_q;
   assign fault_o      = fault_q;
   assign retry_cnt_o  = retry_q;
   assign state_o      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_pll_lock_sequencer
// Brief  : Self-checking bench: table of stimulus phases plus scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_pll_lock_sequencer;
   import pll_seq_pkg::*;

   // Observation vector: {pll_rst, pwrdwn, ready, fault, retry[1:0], state[2:0]}
   localparam logic [8:0] O_RST  = 9'b1_0_0_0_00_000;
   localparam logic [8:0] O_WAIT = 9'b0_0_0_0_00_001;
   localparam logic [8:0] O_STB  = 9'b0_0_0_0_00_010;
   localparam logic [8:0] O_RUN  = 9'b0_0_1_0_00_011;
   localparam logic [8:0] O_PDN  = 9'b1_1_0_0_00_101;
   localparam logic [8:0] M_ALL  = 9'h1FF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, pdn, lk;
   logic       rst2, pdn2, lk2;
   logic       pll_rst, pll_pwrdwn, ready, fault;
   logic [1:0] retry;
   logic [2:0] state;
   logic       pll_rst2, pll_pwrdwn2, ready2, fault2;
   logic [1:0] retry2;
   logic [2:0] state2;

   pll_lock_sequencer u_dut (
      .clk_i(clk), .rst_i(rst), .pwrdwn_req_i(pdn), .pll_locked_i(lk),
      .pll_rst_o(pll_rst), .pll_pwrdwn_o(pll_pwrdwn), .ready_o(ready),
      .fault_o(fault), .retry_cnt_o(retry), .state_o(state)
   );

   pll_lock_sequencer #(.LOCK_TIMEOUT(32)) u_dut_to (
      .clk_i(clk), .rst_i(rst2), .pwrdwn_req_i(pdn2), .pll_locked_i(lk2),
      .pll_rst_o(pll_rst2), .pll_pwrdwn_o(pll_pwrdwn2), .ready_o(ready2),
      .fault_o(fault2), .retry_cnt_o(retry2), .state_o(state2)
   );

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;
   int          n, m;
   int unsigned base;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string       name;
      int unsigned at;
      logic [8:0]  exp;
      logic [8:0]  mask;
   } sb_t;
   sb_t sbq[$];

   typedef struct {
      logic       r, p, l;
      int         n;
      logic [8:0] exp;
      string      name;
   } row_t;
   row_t tbl[15];

   function automatic row_t mk(input logic r, input logic p, input logic l,
                               input int cycles, input logic [8:0] e, input string nm);
      row_t t;
      t.r = r; t.p = p; t.l = l; t.n = cycles; t.exp = e; t.name = nm;
      return t;
   endfunction

   function automatic logic [8:0] obs1();
      return {pll_rst, pll_pwrdwn, ready, fault, retry, state};
   endfunction

   function automatic logic [8:0] obs2();
      return {pll_rst2, pll_pwrdwn2, ready2, fault2, retry2, state2};
   endfunction

   function automatic logic pick(input int which, input int idx);
      logic [8:0] v;
      v = (which == 1) ? obs1() : obs2();
      return v[idx];
   endfunction

   task automatic cmp(input string name, input logic [8:0] act,
                      input logic [8:0] exp, input logic [8:0] mask);
      checks++;
      if ((act & mask) !== (exp & mask)) begin
         failures++;
         $display("FAIL %s: got %b required %b (mask %b) cycle %0d", name, act, exp, mask, cyc);
      end
   endtask

   task automatic cmp_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic push(input string name, input int unsigned at, input logic [8:0] exp);
      sb_t e;
      e.name = name; e.at = at; e.exp = exp; e.mask = M_ALL;
      sbq.push_back(e);
   endtask

   // Counts consecutive negedge samples where the chosen output bit equals lvl.
   task automatic count_while(input int which, input int idx, input logic lvl,
                              input int bound, output int cnt);
      cnt = 0;
      while (pick(which, idx) == lvl && cnt < bound) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   always @(negedge clk) begin
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (sbq[i].at == cyc) begin
            cmp(sbq[i].name, obs1(), sbq[i].exp, sbq[i].mask);
            sbq.delete(i);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; pdn = 1'b0; lk = 1'b0;
      rst2 = 1'b1; pdn2 = 1'b0; lk2 = 1'b0;

      tbl[0]  = mk(0, 0, 0,  3, O_RST,  "loss_to_rst");
      tbl[1]  = mk(0, 0, 0, 16, O_WAIT, "reacq_wait");
      tbl[2]  = mk(0, 1, 0,  1, O_PDN,  "pdn_from_wait");
      tbl[3]  = mk(0, 1, 0,  5, O_PDN,  "pdn_hold");
      tbl[4]  = mk(0, 0, 0,  1, O_RST,  "pdn_release");
      tbl[5]  = mk(0, 0, 0, 15, O_RST,  "pdn_rst_pulse");
      tbl[6]  = mk(0, 0, 0,  1, O_WAIT, "pdn_rst_done");
      tbl[7]  = mk(0, 0, 1,  3, O_STB,  "enter_stable");
      tbl[8]  = mk(1, 1, 1,  1, O_RST,  "rst_overrides_pdn");
      tbl[9]  = mk(1, 1, 1,  2, O_RST,  "rst_hold");
      tbl[10] = mk(0, 1, 1,  1, O_PDN,  "pdn_after_rst");
      tbl[11] = mk(0, 0, 1,  1, O_RST,  "pdn_release2");
      tbl[12] = mk(0, 0, 1, 16, O_WAIT, "rst_pulse_again");
      tbl[13] = mk(0, 0, 1,  1, O_STB,  "locked_to_stable");
      tbl[14] = mk(0, 0, 1, 64, O_RUN,  "stable_to_run");

      repeat (3) @(negedge clk);
      cmp("reset_state", obs1(), O_RST, M_ALL);
      cmp("reset_state_to", obs2(), O_RST, M_ALL);

      // Basic lock
      rst = 1'b0;
      count_while(1, 8, 1'b1, 100, n);
      cmp_int("pll_rst_width_initial", n, 16);
      cmp("wait_entry", obs1(), O_WAIT, M_ALL);
      repeat (100) @(negedge clk);
      cmp("still_waiting", obs1(), O_WAIT, M_ALL);
      lk = 1'b1;
      count_while(1, 6, 1'b0, 200, n);
      cmp_int("ready_latency", n, 67);
      cmp("run_state", obs1(), O_RUN, M_ALL);

      // Run-time loss: one-cycle drop of LOCKED
      lk = 1'b0;
      n = 1;
      @(negedge clk);
      lk = 1'b1;
      count_while(1, 6, 1'b1, 20, m);
      cmp_int("ready_fall_delay", n + m, 3);
      cmp("loss_restart", obs1(), O_RST, M_ALL);
      count_while(1, 8, 1'b1, 100, n);
      cmp_int("pll_rst_width_loss", n, 16);
      count_while(1, 6, 1'b0, 200, n);
      cmp_int("relock_latency", n, 65);
      cmp("relock_run", obs1(), O_RUN, M_ALL);

      // Lock chatter from S_WAIT
      lk = 1'b0;
      repeat (19) @(negedge clk);
      cmp("chatter_wait", obs1(), O_WAIT, M_ALL);
      lk = 1'b1;
      base = cyc;
      push("ch_wait",          base + 2,  O_WAIT);
      push("ch_stable",        base + 3,  O_STB);
      push("ch_stable_late",   base + 12, O_STB);
      push("ch_back_to_wait",  base + 13, O_WAIT);
      push("ch_restable",      base + 14, O_STB);
      push("ch_no_early_ready", base + 77, O_STB);
      push("ch_ready",         base + 78, O_RUN);
      repeat (10) @(negedge clk);
      lk = 1'b0;
      @(negedge clk);
      lk = 1'b1;
      repeat (69) @(negedge clk);

      // Table-driven phases: loss, power-down, reset with PWRDWN_REQ
      for (int i = 0; i < 15; i++) begin
         rst = tbl[i].r; pdn = tbl[i].p; lk = tbl[i].l;
         push(tbl[i].name, cyc + tbl[i].n, tbl[i].exp);
         repeat (tbl[i].n) @(negedge clk);
      end

      // Timeout / retry / fault on the short-timeout instance
      rst2 = 1'b0;
      for (int a = 0; a < 4; a++) begin
         count_while(2, 8, 1'b1, 100, n);
         cmp_int($sformatf("to_rst_pulse%0d", a), n, 16);
         count_while(2, 8, 1'b0, 100, n);
         cmp_int($sformatf("to_wait_len%0d", a), n, 32);
         if (a < 3)
            cmp($sformatf("to_retry%0d", a), obs2(), {4'b1000, 2'(a + 1), 3'd0}, M_ALL);
      end
      cmp("to_fault", obs2(), {4'b1001, 2'd3, 3'd4}, M_ALL);
      repeat (20) @(negedge clk);
      cmp("fault_sticky", obs2(), {4'b1001, 2'd3, 3'd4}, M_ALL);
      pdn2 = 1'b1;
      @(negedge clk);
      cmp("pdn_from_fault", obs2(), O_PDN, 9'b111_0_00_111);
      repeat (3) @(negedge clk);
      pdn2 = 1'b0;
      @(negedge clk);
      cmp("fault_cleared", obs2(), O_RST, M_ALL);
      count_while(2, 8, 1'b1, 100, n);
      cmp_int("to_rst_after_pdn", n, 16);

      repeat (2) @(negedge clk);
      while (sbq.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL sb_pending %s: never compared, due cycle %0d", sbq[0].name, sbq[0].at);
         void'(sbq.pop_front());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
